microseq_ctrl: RTL
==================

// Module: microseq_ctrl
// PURPOSE
//  Parametrised microprogrammed sequencer for the downsampling processor; successor to the fixed 4-phase control unit.
//  Holds the control store, sequences micro-addresses itself (next/dispatch/conditional/halt) and drives control word per step.
//  Generalised in store depth, control width, flag count and phases per micro-step; adds reset, start handshake, error detect.
// PARAMETERS
//  ADDR_W     8     micro-address width
//  CTRL_W     22    control-field width (datapath enables/selects)
//  FLAG_W     4     number of condition flags (bit0 = Z)
//  ROM_DEPTH  43    implemented micro-words; addresses >= ROM_DEPTH are illegal
//  PHASES     4     clock cycles per micro-step (>=1)
//  RESET_VEC  0     micro-address of FETCH1
//  INIT_FILE  "ucode.mem"  $readmemb image; word = {next[ADDR_W], bmode[3], fsel[clog2(FLAG_W)], ctrl[CTRL_W]}
// PORTS
//  clk        in   1       system clock, all logic on posedge
//  rst        in   1       synchronous active-high reset
//  start      in   1       one-cycle pulse; starts microprogram at RESET_VEC
//  opcode     in   ADDR_W  dispatch address (MBRU), sampled at commit
//  flags      in   FLAG_W  ALU condition flags, sampled at commit
//  ctrl       out  CTRL_W  control field of current micro-word; 0 unless RUN
//  upc        out  ADDR_W  address of current micro-word
//  step       out  1       one-cycle pulse on the commit cycle of each micro-step
//  busy       out  1       high in RUN
//  finish     out  1       high in HALT after clean halt
//  err        out  1       high in HALT after illegal address
// BEHAVIOUR
//  Reset: state=IDLE, phase=0, upc=RESET_VEC, mir=0; ctrl=0, step=0, busy=0, finish=0, err=0.
//  Reset wins over every other input on the same edge, including mid-step in RUN.
//  FSM: IDLE -start-> RUN; RUN -HALT word or illegal addr at commit-> HALT; HALT -start-> RUN.
//  Entering RUN: mir<=rom[RESET_VEC], upc<=RESET_VEC, phase<=0, finish/err cleared.
//  start while RUN ignored; rst is the only abort.
//  phase counts 0..PHASES-1 in RUN; commit cycle = phase==PHASES-1; phase wraps to 0.
//  At commit, nxt from current mir.bmode (flag f = flags[mir.fsel]):
//    000 NEXT     nxt = mir.next
//    001 DISPATCH nxt = opcode
//    010 BR_T     nxt = f ? mir.next : upc+1
//    011 BR_F     nxt = f ? upc+1 : mir.next
//    100 HALT     -> HALT, finish=1, upc/mir hold
//    others       treated as HALT with err=1
//  upc+1 wraps mod 2^ADDR_W; the wrapped value passes the range check like any nxt.
//  If nxt >= ROM_DEPTH: -> HALT, err=1, finish=0, upc<=nxt (for debug), mir not loaded.
//  Otherwise mir<=rom[nxt], upc<=nxt on the commit edge; new ctrl visible the cycle after commit.
//  ctrl held constant for all PHASES cycles of a step (datapath latches on any phase it decodes).
//  step=1 exactly on commit cycles in RUN, including the halting commit.
//  PHASES==1: every RUN cycle is a commit; one micro-word per clock.
//  start in same cycle as HALT entry: halt taken, start ignored.
//  No combinational path from opcode/flags to outputs; all outputs registered.
// TESTING
//  rst=1 for 2 cycles with start=1 -> all outputs 0, upc=RESET_VEC, state IDLE after release.
//  Store 0:NEXT->1, 1:DISPATCH, 5:HALT; start, opcode=5, PHASES=4 -> upc 0,1,5 at cycles 4,8; finish at 12; step high at cycles 3,7,11 after start.
//  Word BR_T fsel=0 next=20 at upc 10: Z=1 -> upc=20; rerun with Z=0 -> upc=11.
//  DISPATCH with opcode=60 (ROM_DEPTH=43) -> HALT, err=1, finish=0, upc=60, ctrl=0.
//  rst asserted at phase 2 of a step -> next cycle IDLE, ctrl=0; start then reruns from RESET_VEC cleanly.
//  PHASES=1, ADDR_W=4, ROM_DEPTH=16, BR_F at 15 with f=1 -> upc wraps to 0; start pulsed in RUN ignored.

Source files
------------

// File: rtl/microseq_ctrl_if.sv
// Bundle of the sequencer's control-side signals.
//   start  : one-cycle request to run the microprogram from the reset vector
//   opcode : dispatch address, sampled on a commit cycle
//   flags  : ALU condition flags, sampled on a commit cycle
//   ctrl   : control field of the current micro-word (0 outside RUN)
//   upc    : address of the current micro-word
//   step   : one-cycle pulse on each commit cycle
//   busy   : sequencer is in RUN
//   finish : stopped on a HALT micro-word
//   err    : stopped on an illegal address or branch mode
//   state_dbg : FSM state (0 IDLE, 1 RUN, 2 HALT) for observation
// Handshake: start is a request that is taken only when busy is low (IDLE
// or HALT); busy rising on the next cycle is the acknowledge. A start seen
// while busy is high is dropped, never queued.
interface microseq_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int CTRL_W = 22,
  parameter int FLAG_W = 4
);
  logic              start;
  logic [ADDR_W-1:0] opcode;
  logic [FLAG_W-1:0] flags;
  logic [CTRL_W-1:0] ctrl;
  logic [ADDR_W-1:0] upc;
  logic              step;
  logic              busy;
  logic              finish;
  logic              err;
  logic [1:0]        state_dbg;

  modport master (
    output start, opcode, flags,
    input  ctrl, upc, step, busy, finish, err, state_dbg
  );

  modport slave (
    input  start, opcode, flags,
    output ctrl, upc, step, busy, finish, err, state_dbg
  );
endinterface

// File: rtl/microseq_ctrl.sv
// Microprogrammed sequencer for the downsampling processor.
// Holds the control store, sequences micro-addresses (next, dispatch,
// conditional branch, halt) and presents one control word per micro-step of
// PHASES clock cycles.
// Ports:
//   clk  : system clock, everything on posedge
//   rst  : synchronous active-high reset, wins over every other input
//   bus  : microseq_ctrl_if.slave (start/opcode/flags in; ctrl/upc/step/
//          busy/finish/err/state_dbg out)
// The control store is supplied as the packed parameter ROM_IMAGE; word i
// lives at ROM_IMAGE[i*WORD_W +: WORD_W] with layout
// {next[ADDR_W], bmode[3], fsel[FSEL_W], ctrl[CTRL_W]}.
module microseq_ctrl #(
  parameter int ADDR_W    = 8,
  parameter int CTRL_W    = 22,
  parameter int FLAG_W    = 4,
  parameter int ROM_DEPTH = 43,
  parameter int PHASES    = 4,
  parameter int RESET_VEC = 0,
  localparam int FSEL_W   = (FLAG_W > 1) ? $clog2(FLAG_W) : 1,
  localparam int WORD_W   = ADDR_W + 3 + FSEL_W + CTRL_W,
  parameter logic [ROM_DEPTH*WORD_W-1:0] ROM_IMAGE = '0
) (
  input logic            clk,
  input logic            rst,
  microseq_ctrl_if.slave bus
);

  localparam int PH_W = (PHASES > 1) ? $clog2(PHASES) : 1;
  localparam logic [PH_W-1:0]   LAST_PH = PH_W'(PHASES - 1);
  localparam logic [ADDR_W-1:0] RV      = ADDR_W'(RESET_VEC);

  localparam logic [2:0] BM_NEXT = 3'b000;
  localparam logic [2:0] BM_DISP = 3'b001;
  localparam logic [2:0] BM_BRT  = 3'b010;
  localparam logic [2:0] BM_BRF  = 3'b011;
  localparam logic [2:0] BM_HALT = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [PH_W-1:0]     phase, phase_n;
  logic [ADDR_W-1:0]   upc, upc_n;
  logic [WORD_W-1:0]   mir, mir_n;
  logic                finish_q, finish_n;
  logic                err_q, err_n;
  logic [ADDR_W-1:0]   nxt;
  logic                flag_sel;

  // Micro-instruction register fields.
  logic [ADDR_W-1:0] mir_next;
  logic [2:0]        mir_bmode;
  logic [FSEL_W-1:0] mir_fsel;
  logic [CTRL_W-1:0] mir_ctrl;

  assign mir_next  = mir[WORD_W-1 -: ADDR_W];
  assign mir_bmode = mir[CTRL_W+FSEL_W +: 3];
  assign mir_fsel  = mir[CTRL_W +: FSEL_W];
  assign mir_ctrl  = mir[CTRL_W-1:0];

  // Store read as a decoded mux; addresses beyond the store read as zero
  // but are never loaded because the range check stops the sequencer first.
  function automatic logic [WORD_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    rom_word = '0;
    for (int i = 0; i < ROM_DEPTH; i++) begin
      if (a == ADDR_W'(i)) rom_word = ROM_IMAGE[i*WORD_W +: WORD_W];
    end
  endfunction

  // Condition flag picked by fsel; a select past FLAG_W reads as false.
  always_comb begin
    flag_sel = 1'b0;
    for (int i = 0; i < FLAG_W; i++) begin
      if (mir_fsel == FSEL_W'(i)) flag_sel = bus.flags[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      phase    <= '0;
      upc      <= RV;
      mir      <= '0;
      finish_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      upc      <= upc_n;
      mir      <= mir_n;
      finish_q <= finish_n;
      err_q    <= err_n;
    end
  end

  always_comb begin
    state_n  = state;
    phase_n  = phase;
    upc_n    = upc;
    mir_n    = mir;
    finish_n = finish_q;
    err_n    = err_q;
    nxt      = mir_next;

    case (state)
      IDLE, HALT: begin
        if (bus.start) begin
          state_n  = RUN;
          phase_n  = '0;
          upc_n    = RV;
          mir_n    = rom_word(RV);
          finish_n = 1'b0;
          err_n    = 1'b0;
        end
      end

      RUN: begin
        if (phase == LAST_PH) begin
          phase_n = '0;
          case (mir_bmode)
            BM_NEXT: nxt = mir_next;
            BM_DISP: nxt = bus.opcode;
            BM_BRT:  nxt = flag_sel ? mir_next : upc + ADDR_W'(1);
            BM_BRF:  nxt = flag_sel ? upc + ADDR_W'(1) : mir_next;
            default: nxt = upc;
          endcase

          if (mir_bmode == BM_HALT) begin
            state_n  = HALT;
            finish_n = 1'b1;
          end else if (mir_bmode > BM_HALT) begin
            // Reserved branch modes stop like HALT but flag an error.
            state_n = HALT;
            err_n   = 1'b1;
          end else if (32'(nxt) >= 32'(ROM_DEPTH)) begin
            // Keep the offending address in upc for debug; mir is not loaded.
            state_n = HALT;
            err_n   = 1'b1;
            upc_n   = nxt;
          end else begin
            upc_n = nxt;
            mir_n = rom_word(nxt);
          end
        end else begin
          phase_n = phase + PH_W'(1);
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // All outputs decode registered state only; opcode/flags never reach them
  // combinationally.
  assign bus.ctrl      = (state == RUN) ? mir_ctrl : '0;
  assign bus.upc       = upc;
  assign bus.step      = (state == RUN) && (phase == LAST_PH);
  assign bus.busy      = (state == RUN);
  assign bus.finish    = finish_q;
  assign bus.err       = err_q;
  assign bus.state_dbg = state;

endmodule
